// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle control unit.
// Opcode values/masks are matched against instruction[31:21].
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB
    } state_t;

    typedef enum logic [3:0] {
        ALU_R,
        ALU_I,
        LOAD,
        STORE,
        B,
        BL,
        BR,
        CBZ,
        BCOND,
        ILLEGAL
    } instr_class_t;

    localparam logic [10:0] OP_ADDI    = 11'b10010001000;
    localparam logic [10:0] MASK_ADDI  = 11'b11111111110;
    localparam logic [10:0] OP_ADDS    = 11'b10101011000;
    localparam logic [10:0] OP_SUBS    = 11'b11101011000;
    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    localparam logic [10:0] OP_BR      = 11'b11010110000;
    localparam logic [10:0] MASK_FULL  = 11'b11111111111;
    localparam logic [10:0] OP_B       = 11'b00010100000;
    localparam logic [10:0] OP_BL      = 11'b10010100000;
    localparam logic [10:0] MASK_BRIMM = 11'b11111100000;
    localparam logic [10:0] OP_CBZ     = 11'b10110100000;
    localparam logic [10:0] OP_BCOND   = 11'b01010100000;
    localparam logic [10:0] MASK_CB    = 11'b11111111000;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_OFS = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [4:0] COND_LT = 5'b01011;

    function automatic logic op_match(input logic [10:0] opcode,
                                      input logic [10:0] value,
                                      input logic [10:0] mask);
        return (opcode & mask) == value;
    endfunction

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: maps instruction[31:21] to an instruction class.
// The subtract flag separates SUBS from ADDS within the ALU_R class.
module opcode_classify
    import ctrl_pkg::*;
(
    input  logic [10:0]  opcode,
    output instr_class_t instr_class,
    output logic         subtract
);

    always_comb begin
        instr_class = ILLEGAL;
        subtract    = 1'b0;
        if (op_match(opcode, OP_ADDI, MASK_ADDI)) begin
            instr_class = ALU_I;
        end else if (op_match(opcode, OP_ADDS, MASK_FULL)) begin
            instr_class = ALU_R;
        end else if (op_match(opcode, OP_SUBS, MASK_FULL)) begin
            instr_class = ALU_R;
            subtract    = 1'b1;
        end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
            instr_class = LOAD;
        end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
            instr_class = STORE;
        end else if (op_match(opcode, OP_BR, MASK_FULL)) begin
            instr_class = BR;
        end else if (op_match(opcode, OP_B, MASK_BRIMM)) begin
            instr_class = B;
        end else if (op_match(opcode, OP_BL, MASK_BRIMM)) begin
            instr_class = BL;
        end else if (op_match(opcode, OP_CBZ, MASK_CB)) begin
            instr_class = CBZ;
        end else if (op_match(opcode, OP_BCOND, MASK_CB)) begin
            instr_class = BCOND;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: steps each instruction through FETCH..WB,
// drives the datapath strobes and owns the NZCV flag register.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [3:0]  alu_flags,
    input  logic        dmem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        uncond_br,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        link,
    output logic        dmem_req,
    output logic        dmem_write,
    output logic [3:0]  flags,
    output logic        illegal
);

    state_t       state;
    state_t       next_state;
    instr_class_t instr_class;
    logic         subtract;
    logic         flags_load;
    logic         unused_imm_bits;

    assign unused_imm_bits = ^instruction[20:5];

    opcode_classify u_classify (
        .opcode      (instruction[31:21]),
        .instr_class (instr_class),
        .subtract    (subtract)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            flags <= 4'b0000;
        end else begin
            state <= next_state;
            if (flags_load) begin
                flags <= alu_flags;
            end
        end
    end

    // Strobes are held low for the whole reset cycle, so an in-flight memory request is dropped.
    always_comb begin
        next_state = state;
        flags_load = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_INC;
        uncond_br  = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_PASS;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        dmem_req   = 1'b0;
        dmem_write = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ir_write   = 1'b1;
                    next_state = DECODE;
                end
                DECODE: begin
                    case (instr_class)
                        B, BL: begin
                            pc_src     = PC_OFS;
                            uncond_br  = 1'b1;
                            pc_write   = 1'b1;
                            reg_write  = (instr_class == BL);
                            link       = (instr_class == BL);
                            next_state = FETCH;
                        end
                        BR: begin
                            reg2loc    = 1'b1;
                            pc_src     = PC_REG;
                            pc_write   = 1'b1;
                            next_state = FETCH;
                        end
                        BCOND: begin
                            pc_write   = 1'b1;
                            next_state = FETCH;
                            if (instruction[4:0] == COND_LT) begin
                                pc_src = (flags[3] != flags[0]) ? PC_OFS : PC_INC;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                        ILLEGAL: begin
                            illegal    = 1'b1;
                            pc_write   = 1'b1;
                            next_state = FETCH;
                        end
                        default: next_state = EXECUTE;
                    endcase
                end
                EXECUTE: begin
                    case (instr_class)
                        ALU_R: begin
                            alu_op     = subtract ? ALU_SUB : ALU_ADD;
                            flags_load = 1'b1;
                            next_state = WB;
                        end
                        ALU_I: begin
                            alu_op     = ALU_ADD;
                            alu_src    = 1'b1;
                            next_state = WB;
                        end
                        LOAD, STORE: begin
                            alu_src    = 1'b1;
                            alu_op     = ALU_ADD;
                            reg2loc    = (instr_class == STORE);
                            next_state = MEM;
                        end
                        CBZ: begin
                            reg2loc    = 1'b1;
                            alu_op     = ALU_PASS;
                            pc_src     = alu_flags[2] ? PC_OFS : PC_INC;
                            pc_write   = 1'b1;
                            next_state = FETCH;
                        end
                        default: next_state = FETCH;
                    endcase
                end
                MEM: begin
                    dmem_req   = 1'b1;
                    dmem_write = (instr_class == STORE);
                    reg2loc    = (instr_class == STORE);
                    if (dmem_ready) begin
                        if (instr_class == STORE) begin
                            pc_write   = 1'b1;
                            next_state = FETCH;
                        end else begin
                            next_state = WB;
                        end
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (instr_class == LOAD);
                    pc_write   = 1'b1;
                    next_state = FETCH;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule
